mips_cp0: RTL and testbench

Coprocessor-0 block for the 64-bit MIPS pipeline, instantiated in the memory stage. It holds the Status, Cause and EPC system registers and serves MFC0/MTC0 accesses. It detects synchronous exceptions and masked external interrupts, and raises a single-cycle `takenHandler` request to the fetch logic. It records the return PC in EPC and clears exception level on ERET.

---
 rtl/mips_cp0_if.sv | 34 +++
 rtl/mips_cp0.sv | 114 +++++++++++
 tb/tb_mips_cp0.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cp0_if.sv
// Pipeline <-> coprocessor-0 access and exception-cause bundle.
// Latency: none; this bundle only groups signals.
// Backpressure: none; all signals are sampled or driven every cycle.
interface mips_cp0_if;
   logic [63:0] rd_data;
   logic [63:0] EPC;
   logic        takenHandler;
   logic [63:0] wr_data;
   logic [4:0]  regnum;
   logic [2:0]  sel;
   logic [63:0] IF_pc;
   logic [63:0] curr_pc;
   logic        MTC0;
   logic        ERET;
   logic [7:0]  interrupt_source;
   logic        overflow;
   logic        reserved_inst;
   logic        break_;
   logic        syscall;

   // Pipeline side: drives accesses and causes, observes read data and redirect.
   modport master (
      output wr_data, regnum, sel, IF_pc, curr_pc, MTC0, ERET,
             interrupt_source, overflow, reserved_inst, break_, syscall,
      input  rd_data, EPC, takenHandler
   );

   // Coprocessor side.
   modport slave (
      input  wr_data, regnum, sel, IF_pc, curr_pc, MTC0, ERET,
             interrupt_source, overflow, reserved_inst, break_, syscall,
      output rd_data, EPC, takenHandler
   );
endinterface

// File: rtl/mips_cp0.sv
// Coprocessor 0: Status/Cause/EPC, MFC0/MTC0, exception and interrupt entry, ERET.
// Latency: reads and takenHandler are combinational; state updates on the next edge.
// Backpressure: none; one access and at most one taken event per cycle.
module mips_cp0 (
   input logic       clock,
   input logic       reset,
   mips_cp0_if.slave cp0
);

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_BP  = 5'd9;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   logic        ie_q, ie_d;
   logic        exl_q, exl_d;
   logic [7:0]  im_q, im_d;
   logic [4:0]  code_q, code_d;
   logic [63:0] epc_q, epc_d;

   logic        sel0;
   logic        exc;
   logic        irq;
   logic        taken;
   logic [4:0]  win_code;
   logic        wr_status;
   logic        wr_epc;
   logic [63:0] status_val;
   logic [63:0] cause_val;

   assign sel0      = (cp0.sel == 3'd0);
   assign wr_status = cp0.MTC0 & sel0 & (cp0.regnum == REG_STATUS);
   assign wr_epc    = cp0.MTC0 & sel0 & (cp0.regnum == REG_EPC);

   assign exc   = cp0.overflow | cp0.reserved_inst | cp0.break_ | cp0.syscall;
   assign irq   = (|(cp0.interrupt_source & im_q)) & ie_q;
   // EXL blocks nesting, so a taken event lasts exactly one cycle.
   assign taken = ~exl_q & (exc | irq);

   assign status_val = {48'd0, im_q, 6'd0, exl_q, ie_q};
   // IP bits are the live interrupt lines, not a registered copy.
   assign cause_val  = {48'd0, cp0.interrupt_source, 1'b0, code_q, 2'b00};

   // Fixed priority among simultaneous causes; interrupt is lowest.
   always_comb begin
      win_code = EXC_INT;
      if (cp0.reserved_inst)  win_code = EXC_RI;
      else if (cp0.syscall)   win_code = EXC_SYS;
      else if (cp0.break_)    win_code = EXC_BP;
      else if (cp0.overflow)  win_code = EXC_OV;
   end

   // Next-state: a taken event overrides any MTC0/ERET this cycle.
   always_comb begin
      ie_d   = ie_q;
      exl_d  = exl_q;
      im_d   = im_q;
      code_d = code_q;
      epc_d  = epc_q;
      if (taken) begin
         exl_d  = 1'b1;
         code_d = win_code;
         epc_d  = exc ? cp0.curr_pc : cp0.IF_pc;
      end else begin
         if (wr_status) begin
            ie_d  = cp0.wr_data[0];
            exl_d = cp0.wr_data[1];
            im_d  = cp0.wr_data[15:8];
         end
         if (wr_epc) epc_d = cp0.wr_data;
         // ERET wins over a same-cycle Status write for EXL only.
         if (cp0.ERET) exl_d = 1'b0;
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ie_q   <= 1'b0;
         exl_q  <= 1'b0;
         im_q   <= 8'd0;
         code_q <= 5'd0;
         epc_q  <= 64'd0;
      end else begin
         ie_q   <= ie_d;
         exl_q  <= exl_d;
         im_q   <= im_d;
         code_q <= code_d;
         epc_q  <= epc_d;
      end
   end

   // MFC0 read mux; unimplemented registers and nonzero selects read zero.
   always_comb begin
      cp0.rd_data = 64'd0;
      if (sel0) begin
         case (cp0.regnum)
            REG_STATUS: cp0.rd_data = status_val;
            REG_CAUSE:  cp0.rd_data = cause_val;
            REG_EPC:    cp0.rd_data = epc_q;
            default:    cp0.rd_data = 64'd0;
         endcase
      end
   end

   assign cp0.EPC          = epc_q;
   assign cp0.takenHandler = taken;

endmodule

// File: tb/tb_mips_cp0.sv
// Directed bench for mips_cp0 with an expectation queue checked against outputs.
module tb_mips_cp0;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   mips_cp0_if bus();

   mips_cp0 dut (
      .clock (clock),
      .reset (reset),
      .cp0   (bus)
   );

   typedef struct {
      int          kind;   // 0 rd_data, 1 EPC, 2 takenHandler
      logic [63:0] val;
   } exp_t;

   exp_t  sb[$];
   int    total = 0;
   int    bad   = 0;
   string step  = "init";

   task automatic push_exp(input int kind, input logic [63:0] v);
      exp_t e;
      e.kind = kind;
      e.val  = v;
      sb.push_back(e);
   endtask

   // Drain the queue, comparing each entry with the current output value.
   task automatic check_out();
      exp_t        e;
      logic [63:0] obs;
      string       nm;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            0:       begin obs = bus.rd_data;                nm = "rd_data"; end
            1:       begin obs = bus.EPC;                    nm = "EPC";     end
            default: begin obs = {63'd0, bus.takenHandler}; nm = "taken";   end
         endcase
         total++;
         assert (obs === e.val)
         else begin
            bad++;
            $error("FAIL %s.%s observed=%h expected=%h", step, nm, obs, e.val);
         end
      end
   endtask

   task automatic read_chk(input logic [4:0] r, input logic [2:0] s, input logic [63:0] v);
      bus.regnum = r;
      bus.sel    = s;
      push_exp(0, v);
      check_out();
   endtask

   task automatic taken_chk(input logic v);
      push_exp(2, {63'd0, v});
      check_out();
   endtask

   task automatic epc_chk(input logic [63:0] v);
      push_exp(1, v);
      check_out();
   endtask

   // Advance one edge, then drop all single-cycle strobes.
   task automatic tick();
      @(posedge clock);
      #1;
      bus.MTC0          = 1'b0;
      bus.ERET          = 1'b0;
      bus.overflow      = 1'b0;
      bus.reserved_inst = 1'b0;
      bus.break_        = 1'b0;
      bus.syscall       = 1'b0;
   endtask

   task automatic mtc0(input logic [4:0] r, input logic [63:0] v);
      bus.MTC0    = 1'b1;
      bus.regnum  = r;
      bus.sel     = 3'd0;
      bus.wr_data = v;
   endtask

   initial begin
      reset                = 1'b1;
      bus.wr_data          = '0;
      bus.regnum           = '0;
      bus.sel              = '0;
      bus.IF_pc            = '0;
      bus.curr_pc          = '0;
      bus.MTC0             = 1'b0;
      bus.ERET             = 1'b0;
      bus.interrupt_source = '0;
      bus.overflow         = 1'b0;
      bus.reserved_inst    = 1'b0;
      bus.break_           = 1'b0;
      bus.syscall          = 1'b0;
      #3;

      step = "reset";
      read_chk(5'd12, 3'd0, 64'h0);
      read_chk(5'd13, 3'd0, 64'h0);
      read_chk(5'd14, 3'd0, 64'h0);
      taken_chk(1'b0);
      epc_chk(64'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      read_chk(5'd12, 3'd1, 64'h0);

      step = "status_wr";
      mtc0(5'd12, 64'h0000_0301);
      taken_chk(1'b0);
      tick();
      read_chk(5'd12, 3'd0, 64'h301);

      step = "irq";
      bus.IF_pc            = 64'h1000;
      bus.curr_pc          = 64'h0bad;
      bus.interrupt_source = 8'h01;
      taken_chk(1'b1);
      tick();
      epc_chk(64'h1000);
      read_chk(5'd12, 3'd0, 64'h303);
      read_chk(5'd13, 3'd0, 64'h100);
      taken_chk(1'b0);
      bus.interrupt_source = 8'h00;
      bus.ERET = 1'b1;
      tick();
      read_chk(5'd12, 3'd0, 64'h301);

      step = "syscall";
      bus.curr_pc = 64'h2004;
      bus.syscall = 1'b1;
      taken_chk(1'b1);
      tick();
      read_chk(5'd13, 3'd0, 64'h20);
      epc_chk(64'h2004);
      taken_chk(1'b0);
      bus.ERET = 1'b1;
      tick();
      read_chk(5'd12, 3'd0, 64'h301);

      step = "priority";
      bus.curr_pc       = 64'h2100;
      bus.overflow      = 1'b1;
      bus.reserved_inst = 1'b1;
      taken_chk(1'b1);
      tick();
      read_chk(5'd13, 3'd0, 64'h28);
      epc_chk(64'h2100);
      bus.curr_pc = 64'h5555;
      bus.break_  = 1'b1;
      taken_chk(1'b0);
      tick();
      epc_chk(64'h2100);
      read_chk(5'd13, 3'd0, 64'h28);
      bus.ERET = 1'b1;
      tick();

      step = "mask_ie0";
      mtc0(5'd12, 64'h0000_ff00);
      tick();
      bus.interrupt_source = 8'hff;
      taken_chk(1'b0);
      read_chk(5'd13, 3'd0, 64'hff28);
      step = "mask_im0";
      mtc0(5'd12, 64'h0000_0001);
      taken_chk(1'b0);
      tick();
      taken_chk(1'b0);
      read_chk(5'd12, 3'd0, 64'h1);
      bus.interrupt_source = 8'h00;

      step = "collision";
      mtc0(5'd14, 64'hdead);
      bus.curr_pc  = 64'h3000;
      bus.overflow = 1'b1;
      taken_chk(1'b1);
      tick();
      epc_chk(64'h3000);
      read_chk(5'd13, 3'd0, 64'h30);
      read_chk(5'd12, 3'd0, 64'h3);
      bus.ERET = 1'b1;
      tick();

      step = "epc_wr";
      mtc0(5'd14, 64'hbeef);
      tick();
      epc_chk(64'hbeef);

      step = "eret_mtc0";
      bus.curr_pc = 64'h4000;
      bus.syscall = 1'b1;
      tick();
      read_chk(5'd12, 3'd0, 64'h3);
      mtc0(5'd12, 64'h0000_0203);
      bus.ERET = 1'b1;
      tick();
      read_chk(5'd12, 3'd0, 64'h201);

      step = "async_reset";
      bus.curr_pc  = 64'h6000;
      bus.overflow = 1'b1;
      tick();
      epc_chk(64'h6000);
      #2;
      reset = 1'b1;
      read_chk(5'd12, 3'd0, 64'h0);
      epc_chk(64'h0);
      read_chk(5'd13, 3'd0, 64'h0);
      reset = 1'b0;
      tick();

      step = "retrigger";
      mtc0(5'd12, 64'h0000_0101);
      tick();
      bus.IF_pc            = 64'h7000;
      bus.interrupt_source = 8'h01;
      taken_chk(1'b1);
      tick();
      taken_chk(1'b0);
      bus.ERET = 1'b1;
      tick();
      bus.IF_pc = 64'h7008;
      taken_chk(1'b1);
      tick();
      epc_chk(64'h7008);
      bus.interrupt_source = 8'h00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
